// File: rtl/rst_seq_ctrl.sv
// Startup/recovery reset sequencer: waits for a stable PLL lock, then releases the
// receiver, tx-payload and tx-signal reset requests in a fixed staggered order.
module rst_seq_ctrl #(
  parameter int unsigned LOCK_STABLE_CYC = 64,
  parameter int unsigned GAP_CYC         = 16,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked_i,
  input  logic       soft_rst_i,
  output logic       rst_recv_o,
  output logic       rst_pld_o,
  output logic       rst_sig_o,
  output logic       seq_done_o,
  output logic [2:0] state_o,
  output logic [7:0] lock_lost_cnt_o
);

  localparam logic [2:0] StWaitLock = 3'd0;
  localparam logic [2:0] StRelRecv  = 3'd1;
  localparam logic [2:0] StRelPld   = 3'd2;
  localparam logic [2:0] StRelSig   = 3'd3;
  localparam logic [2:0] StRun      = 3'd4;
  localparam logic [2:0] StHold     = 3'd5;

  localparam logic [CNT_W-1:0] LockLast = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_CYC - 1);

  logic             sync_q, lk_q;
  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lost_cnt_q, lost_cnt_d;
  logic             rst_recv_q, rst_recv_d;
  logic             rst_pld_q, rst_pld_d;
  logic             rst_sig_q, rst_sig_d;
  logic             done_q, done_d;
  logic             lost_evt;

  // Two-flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      lk_q   <= 1'b0;
    end else begin
      sync_q <= pll_locked_i;
      lk_q   <= sync_q;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lost_evt = 1'b0;
    unique case (state_q)
      StWaitLock: begin
        if (soft_rst_i) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (!lk_q) begin
          cnt_d = '0;
        end else if (cnt_q == LockLast) begin
          state_d = StRelRecv;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRelRecv, StRelPld, StRelSig: begin
        if (!lk_q) begin
          state_d  = StHold;
          cnt_d    = '0;
          lost_evt = 1'b1;
        end else if (soft_rst_i) begin
          state_d = StHold;
          cnt_d   = '0;
        end else if (cnt_q == GapLast) begin
          state_d = state_q + 3'd1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lk_q) begin
          state_d  = StHold;
          cnt_d    = '0;
          lost_evt = 1'b1;
        end else if (soft_rst_i) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (cnt_q >= GapLast && !soft_rst_i) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q < GapLast) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StHold;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    lost_cnt_d = lost_cnt_q;
    if (lost_evt && lost_cnt_q != 8'hFF) begin
      lost_cnt_d = lost_cnt_q + 8'd1;
    end
  end

  // Outputs are decoded from the next state and registered alongside it, so they
  // change on the same edge as state_q and never glitch.
  always_comb begin
    rst_recv_d = 1'b1;
    rst_pld_d  = 1'b1;
    rst_sig_d  = 1'b1;
    done_d     = 1'b0;
    case (state_d)
      StRelRecv: rst_recv_d = 1'b0;
      StRelPld: begin
        rst_recv_d = 1'b0;
        rst_pld_d  = 1'b0;
      end
      StRelSig: begin
        rst_recv_d = 1'b0;
        rst_pld_d  = 1'b0;
        rst_sig_d  = 1'b0;
      end
      StRun: begin
        rst_recv_d = 1'b0;
        rst_pld_d  = 1'b0;
        rst_sig_d  = 1'b0;
        done_d     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StWaitLock;
      cnt_q      <= '0;
      lost_cnt_q <= 8'd0;
      rst_recv_q <= 1'b1;
      rst_pld_q  <= 1'b1;
      rst_sig_q  <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lost_cnt_q <= lost_cnt_d;
      rst_recv_q <= rst_recv_d;
      rst_pld_q  <= rst_pld_d;
      rst_sig_q  <= rst_sig_d;
      done_q     <= done_d;
    end
  end

  assign rst_recv_o      = rst_recv_q;
  assign rst_pld_o       = rst_pld_q;
  assign rst_sig_o       = rst_sig_q;
  assign seq_done_o      = done_q;
  assign state_o         = state_q;
  assign lock_lost_cnt_o = lost_cnt_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with LOCK_STABLE_CYC=64, GAP_CYC=16.
module tb_rst_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked_i = 1'b0;
  logic       soft_rst_i = 1'b0;
  logic       rst_recv_o, rst_pld_o, rst_sig_o, seq_done_o;
  logic [2:0] state_o;
  logic [7:0] lock_lost_cnt_o;

  int total = 0;
  int bad = 0;

  // {recv, pld, sig, done, state}
  localparam logic [6:0] VWait = 7'b1110_000;
  localparam logic [6:0] VRecv = 7'b0110_001;
  localparam logic [6:0] VPld  = 7'b0010_010;
  localparam logic [6:0] VSig  = 7'b0000_011;
  localparam logic [6:0] VRun  = 7'b0001_100;
  localparam logic [6:0] VHold = 7'b1110_101;

  wire [6:0] obs = {rst_recv_o, rst_pld_o, rst_sig_o, seq_done_o, state_o};

  rst_seq_ctrl #(
    .LOCK_STABLE_CYC(64),
    .GAP_CYC        (16),
    .CNT_W          (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pll_locked_i   (pll_locked_i),
    .soft_rst_i     (soft_rst_i),
    .rst_recv_o     (rst_recv_o),
    .rst_pld_o      (rst_pld_o),
    .rst_sig_o      (rst_sig_o),
    .seq_done_o     (seq_done_o),
    .state_o        (state_o),
    .lock_lost_cnt_o(lock_lost_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    pll_locked_i = 1'b0;
    soft_rst_i = 1'b0;
    step(3);
    total++;
    if (obs !== VWait || lock_lost_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL reset_state got=%b/%0d want=%b/0", obs, lock_lost_cnt_o, VWait);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_startup;
    int          edges [8] = '{65, 66, 81, 82, 97, 98, 113, 114};
    logic [6:0]  exps  [8] = '{VWait, VRecv, VRecv, VPld, VPld, VSig, VSig, VRun};
    int          e = 0;
    pll_locked_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(edges[i] - e);
      e = edges[i];
      total++;
      if (obs !== exps[i]) begin
        bad++;
        $display("FAIL startup_edge%0d got=%b want=%b", e, obs, exps[i]);
      end
    end
  endtask

  task automatic test_lock_loss_run;
    pll_locked_i = 1'b0;
    step(2);
    total++;
    if (obs !== VRun) begin
      bad++;
      $display("FAIL loss_edge2 got=%b want=%b", obs, VRun);
    end
    step(1);
    total++;
    if (obs !== VHold || lock_lost_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL loss_edge3 got=%b/%0d want=%b/1", obs, lock_lost_cnt_o, VHold);
    end
    pll_locked_i = 1'b1;
    step(15);
    total++;
    if (obs !== VHold) begin
      bad++;
      $display("FAIL loss_hold_end got=%b want=%b", obs, VHold);
    end
    step(1);
    total++;
    if (obs !== VWait) begin
      bad++;
      $display("FAIL loss_hold_exit got=%b want=%b", obs, VWait);
    end
    step(63);
    total++;
    if (obs !== VWait) begin
      bad++;
      $display("FAIL loss_relock_early got=%b want=%b", obs, VWait);
    end
    step(1);
    total++;
    if (obs !== VRecv) begin
      bad++;
      $display("FAIL loss_relock_recv got=%b want=%b", obs, VRecv);
    end
    step(48);
    total++;
    if (obs !== VRun || lock_lost_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL loss_rerun got=%b/%0d want=%b/1", obs, lock_lost_cnt_o, VRun);
    end
  endtask

  task automatic test_glitch;
    rst_n = 1'b0;
    pll_locked_i = 1'b1;
    step(2);
    rst_n = 1'b1;
    step(44);
    pll_locked_i = 1'b0;
    step(1);
    pll_locked_i = 1'b1;
    step(65);
    total++;
    if (obs !== VWait) begin
      bad++;
      $display("FAIL glitch_edge110 got=%b want=%b", obs, VWait);
    end
    step(1);
    total++;
    if (obs !== VRecv || lock_lost_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL glitch_edge111 got=%b/%0d want=%b/0", obs, lock_lost_cnt_o, VRecv);
    end
  endtask

  task automatic test_soft;
    step(16);
    total++;
    if (obs !== VPld) begin
      bad++;
      $display("FAIL soft_reach_pld got=%b want=%b", obs, VPld);
    end
    step(3);
    soft_rst_i = 1'b1;
    step(1);
    soft_rst_i = 1'b0;
    total++;
    if (obs !== VHold || lock_lost_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL soft_pulse got=%b/%0d want=%b/0", obs, lock_lost_cnt_o, VHold);
    end
    step(15);
    total++;
    if (obs !== VHold) begin
      bad++;
      $display("FAIL soft_hold_end got=%b want=%b", obs, VHold);
    end
    step(1);
    total++;
    if (obs !== VWait) begin
      bad++;
      $display("FAIL soft_hold_exit got=%b want=%b", obs, VWait);
    end
    soft_rst_i = 1'b1;
    step(40);
    total++;
    if (obs !== VHold) begin
      bad++;
      $display("FAIL soft_long_hold got=%b want=%b", obs, VHold);
    end
    soft_rst_i = 1'b0;
    step(1);
    total++;
    if (obs !== VWait) begin
      bad++;
      $display("FAIL soft_long_exit got=%b want=%b", obs, VWait);
    end
  endtask

  task automatic test_simul_and_async;
    step(111);
    total++;
    if (obs !== VSig) begin
      bad++;
      $display("FAIL simul_pre_sig got=%b want=%b", obs, VSig);
    end
    step(1);
    total++;
    if (obs !== VRun) begin
      bad++;
      $display("FAIL simul_pre_run got=%b want=%b", obs, VRun);
    end
    pll_locked_i = 1'b0;
    step(2);
    soft_rst_i = 1'b1;
    step(1);
    total++;
    if (obs !== VHold || lock_lost_cnt_o !== 8'd1) begin
      bad++;
      $display("FAIL simul_fault got=%b/%0d want=%b/1", obs, lock_lost_cnt_o, VHold);
    end
    soft_rst_i = 1'b0;
    pll_locked_i = 1'b1;
    step(115);
    total++;
    if (obs !== VSig) begin
      bad++;
      $display("FAIL async_pre_sig got=%b want=%b", obs, VSig);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (obs !== VWait || lock_lost_cnt_o !== 8'd0) begin
      bad++;
      $display("FAIL async_reset got=%b/%0d want=%b/0", obs, lock_lost_cnt_o, VWait);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_saturation;
    int timeouts = 0;
    pll_locked_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < 200 && state_o != 3'd1; k++) step(1);
      if (state_o != 3'd1) timeouts++;
      pll_locked_i = 1'b0;
      for (int k = 0; k < 10 && state_o != 3'd5; k++) step(1);
      if (state_o != 3'd5) timeouts++;
      pll_locked_i = 1'b1;
      if (i == 99) begin
        total++;
        if (lock_lost_cnt_o !== 8'd100) begin
          bad++;
          $display("FAIL sat_count100 got=%0d want=100", lock_lost_cnt_o);
        end
      end
    end
    total++;
    if (timeouts != 0) begin
      bad++;
      $display("FAIL sat_timeouts got=%0d want=0", timeouts);
    end
    total++;
    if (lock_lost_cnt_o !== 8'd255) begin
      bad++;
      $display("FAIL sat_count got=%0d want=255", lock_lost_cnt_o);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_startup();
    test_lock_loss_run();
    test_glitch();
    test_soft();
    test_simul_and_async();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
